// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage between execute and writeback.
// Single-outstanding load/store handshake, load extract, store lanes.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_rd2,
  input  logic [4:0]  i_write_reg,
  input  logic        i_mem_to_reg,
  input  logic        i_reg_write,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_func3,
  input  logic        i_branch,
  input  logic [31:0] i_add_sum,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ready,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_wb_valid,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_wb_write_reg,
  output logic        o_wb_reg_write,
  output logic        o_pc_src,
  output logic [31:0] o_branch_target,
  output logic        o_mem_err
);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  localparam logic [7:0] LP_TMO_LAST =
    8'(TIMEOUT_CYCLES - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]  r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_alu;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [2:0]  r_f3;
  logic [4:0]  r_wr_reg;
  logic        r_rw;
  logic        r_wb_valid;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_reg;
  logic        r_wb_rw;
  logic        r_pc_src;
  logic [31:0] r_target;
  logic        r_err;

  logic        w_is_mem;
  logic [1:0]  w_off;
  logic        w_dec_err;
  logic        w_cap;
  logic        w_wb_alu;
  logic        w_err_now;
  logic        w_done;
  logic        w_tmo;
  logic        w_br;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sx;
  logic [31:0] w_load;
  logic        w_unused;

  assign w_unused = i_mem_to_reg;

  assign w_is_mem = i_mem_read | i_mem_write;
  assign w_off    = i_alu_out[1:0];

  always_comb begin
    w_dec_err = 1'b0;
    if (i_mem_read & i_mem_write)
      w_dec_err = 1'b1;
    if (i_mem_read & (i_func3 == 3'd3 ||
        i_func3 == 3'd6 || i_func3 == 3'd7))
      w_dec_err = 1'b1;
    if (i_mem_write & (i_func3 > 3'd2))
      w_dec_err = 1'b1;
    if ((i_func3[1:0] == 2'b01) & w_off[0])
      w_dec_err = 1'b1;
    if ((i_func3[1:0] == 2'b10) & (|w_off))
      w_dec_err = 1'b1;
    w_dec_err = w_dec_err & w_is_mem;
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_rd2;
    unique case (1'b1)
      i_func3[1:0] == 2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{i_rd2[7:0]}};
      end
      i_func3[1:0] == 2'b01: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_rd2[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = i_rd2;
      end
    endcase
  end

  assign w_shift = i_dmem_rdata >> {r_alu[1:0], 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = r_alu[1] ? i_dmem_rdata[31:16]
                            : i_dmem_rdata[15:0];
  assign w_sx    = ~r_f3[2];

  always_comb begin
    w_load = i_dmem_rdata;
    unique case (1'b1)
      r_f3[1:0] == 2'b00:
        w_load = {{24{w_sx & w_byte[7]}}, w_byte};
      r_f3[1:0] == 2'b01:
        w_load = {{16{w_sx & w_half[15]}}, w_half};
      default:
        w_load = i_dmem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_wb_alu    = 1'b0;
    w_err_now   = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          if (!w_is_mem) begin
            w_wb_alu = 1'b1;
          end else if (w_dec_err) begin
            w_err_now = 1'b1;
          end else begin
            w_cap       = 1'b1;
            w_state_nxt = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        // ready on the timeout edge still completes normally
        if (i_dmem_ready) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == LP_TMO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_br = i_valid & i_branch & (r_state == S_IDLE);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt      <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_alu      <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_f3       <= '0;
      r_wr_reg   <= '0;
      r_rw       <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_wb_reg   <= '0;
      r_wb_rw    <= 1'b0;
      r_pc_src   <= 1'b0;
      r_target   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wb_valid <= w_wb_alu | w_err_now | w_done | w_tmo;
      r_err      <= w_err_now | w_tmo;
      r_pc_src   <= w_br;
      if (w_br)
        r_target <= i_add_sum;
      if (w_wb_alu) begin
        r_wb_data <= i_alu_out;
        r_wb_reg  <= i_write_reg;
        r_wb_rw   <= i_reg_write;
      end
      if (w_err_now) begin
        r_wb_data <= i_alu_out;
        r_wb_reg  <= i_write_reg;
        r_wb_rw   <= 1'b0;
      end
      if (w_cap) begin
        r_cnt    <= '0;
        r_req    <= 1'b1;
        r_we     <= i_mem_write;
        r_alu    <= i_alu_out;
        r_wdata  <= w_wdata;
        r_be     <= w_be;
        r_f3     <= i_func3;
        r_wr_reg <= i_write_reg;
        r_rw     <= i_reg_write;
      end
      if ((r_state == S_ACCESS) & ~w_done & ~w_tmo)
        r_cnt <= r_cnt + 8'd1;
      if (w_done) begin
        r_req     <= 1'b0;
        r_wb_data <= r_we ? r_alu : w_load;
        r_wb_reg  <= r_wr_reg;
        r_wb_rw   <= ~r_we & r_rw;
      end
      if (w_tmo) begin
        r_req     <= 1'b0;
        r_wb_data <= r_alu;
        r_wb_reg  <= r_wr_reg;
        r_wb_rw   <= 1'b0;
      end
    end
  end

  assign o_stall         = (r_state == S_ACCESS);
  assign o_dmem_req      = r_req;
  assign o_dmem_we       = r_we;
  assign o_dmem_addr     = {r_alu[31:2], 2'b00};
  assign o_dmem_wdata    = r_wdata;
  assign o_dmem_be       = r_be;
  assign o_wb_valid      = r_wb_valid;
  assign o_wb_data       = r_wb_data;
  assign o_wb_write_reg  = r_wb_reg;
  assign o_wb_reg_write  = r_wb_rw;
  assign o_pc_src        = r_pc_src;
  assign o_branch_target = r_target;
  assign o_mem_err       = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage.
// Expected WB, request and redirect events are queued and popped by monitors.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_alu_out = '0;
  logic [31:0] i_rd2 = '0;
  logic [4:0]  i_write_reg = '0;
  logic        i_mem_to_reg = 1'b0;
  logic        i_reg_write = 1'b0;
  logic        i_mem_read = 1'b0;
  logic        i_mem_write = 1'b0;
  logic [2:0]  i_func3 = '0;
  logic        i_branch = 1'b0;
  logic [31:0] i_add_sum = '0;
  logic        o_stall;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ready = 1'b0;
  logic [31:0] i_dmem_rdata = '0;
  logic        o_wb_valid;
  logic [31:0] o_wb_data;
  logic [4:0]  o_wb_write_reg;
  logic        o_wb_reg_write;
  logic        o_pc_src;
  logic [31:0] o_branch_target;
  logic        o_mem_err;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  r;
    logic        rw;
    logic        err;
    logic        full;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } rq_t;

  wb_t         wbq[$];
  rq_t         rqq[$];
  logic [31:0] bq[$];

  int n_tests = 0;
  int n_fail  = 0;
  logic prev_req = 1'b0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_valid(i_valid),
    .i_alu_out(i_alu_out),
    .i_rd2(i_rd2),
    .i_write_reg(i_write_reg),
    .i_mem_to_reg(i_mem_to_reg),
    .i_reg_write(i_reg_write),
    .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write),
    .i_func3(i_func3),
    .i_branch(i_branch),
    .i_add_sum(i_add_sum),
    .o_stall(o_stall),
    .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata),
    .o_dmem_be(o_dmem_be),
    .i_dmem_ready(i_dmem_ready),
    .i_dmem_rdata(i_dmem_rdata),
    .o_wb_valid(o_wb_valid),
    .o_wb_data(o_wb_data),
    .o_wb_write_reg(o_wb_write_reg),
    .o_wb_reg_write(o_wb_reg_write),
    .o_pc_src(o_pc_src),
    .o_branch_target(o_branch_target),
    .o_mem_err(o_mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // writeback monitor
  always @(negedge clk) begin
    if (rst_n && o_wb_valid) begin
      if (wbq.size() == 0) begin
        chk("wb_unexpected", 32'(o_wb_valid), 32'd0);
      end else begin
        wb_t e;
        e = wbq.pop_front();
        if (e.full) begin
          chk("wb_data", o_wb_data, e.d);
          chk("wb_reg", 32'(o_wb_write_reg), 32'(e.r));
        end
        chk("wb_rw", 32'(o_wb_reg_write), 32'(e.rw));
        chk("wb_err", 32'(o_mem_err), 32'(e.err));
      end
    end
    if (rst_n && o_mem_err && !o_wb_valid)
      chk("err_no_wb", 32'(o_wb_valid), 32'd1);
  end

  // request monitor
  always @(negedge clk) begin
    if (rst_n && o_dmem_req && !prev_req) begin
      if (rqq.size() == 0) begin
        chk("req_unexpected", 32'(o_dmem_req), 32'd0);
      end else begin
        rq_t q;
        q = rqq.pop_front();
        chk("req_addr", o_dmem_addr, q.addr);
        chk("req_we", 32'(o_dmem_we), 32'(q.we));
        if (q.we) begin
          chk("req_be", 32'(o_dmem_be), 32'(q.be));
          chk("req_wdata", o_dmem_wdata, q.wdata);
        end
      end
    end
    prev_req <= o_dmem_req;
  end

  // redirect monitor
  always @(negedge clk) begin
    if (rst_n && o_pc_src) begin
      if (bq.size() == 0) begin
        chk("br_unexpected", 32'(o_pc_src), 32'd0);
      end else begin
        logic [31:0] t;
        t = bq.pop_front();
        chk("br_target", o_branch_target, t);
      end
    end
  end

  function automatic wb_t mk_wb(input logic [31:0] d,
                                input logic [4:0] r,
                                input logic rw,
                                input logic err,
                                input logic full);
    wb_t e;
    e.d = d; e.r = r; e.rw = rw;
    e.err = err; e.full = full;
    return e;
  endfunction

  function automatic rq_t mk_rq(input logic [31:0] a,
                                input logic we,
                                input logic [3:0] be,
                                input logic [31:0] wd);
    rq_t q;
    q.addr = a; q.we = we; q.be = be; q.wdata = wd;
    return q;
  endfunction

  // issue one entry; upstream holds it while stalled
  task automatic run_op(input string nm,
                        input logic rd, input logic wr,
                        input logic [2:0] f3,
                        input logic [31:0] alu,
                        input logic [31:0] rd2,
                        input logic [4:0] wreg,
                        input logic rw,
                        input logic br,
                        input logic [31:0] tgt,
                        input logic [31:0] rdata,
                        input int rdy_at,
                        input int exp_stall);
    int n;
    i_valid      = 1'b1;
    i_mem_read   = rd;
    i_mem_write  = wr;
    i_mem_to_reg = rd;
    i_func3      = f3;
    i_alu_out    = alu;
    i_rd2        = rd2;
    i_write_reg  = wreg;
    i_reg_write  = rw;
    i_branch     = br;
    i_add_sum    = tgt;
    @(posedge clk); #1;
    if (exp_stall == 0)
      chk({nm, "_lat"}, 32'(o_wb_valid), 32'd1);
    n = 0;
    while (o_stall && n < 40) begin
      i_dmem_ready = (n == rdy_at);
      i_dmem_rdata = rdata;
      @(posedge clk); #1;
      n++;
    end
    i_dmem_ready = 1'b0;
    i_valid      = 1'b0;
    i_branch     = 1'b0;
    i_mem_read   = 1'b0;
    i_mem_write  = 1'b0;
    chk({nm, "_stall"}, 32'(n), 32'(exp_stall));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs",
        {27'd0, o_wb_valid, o_dmem_req, o_stall,
         o_pc_src, o_mem_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU op
    wbq.push_back(mk_wb(32'h1234, 5'd5, 1'b1, 1'b0, 1'b1));
    run_op("alu", 0, 0, 3'd0, 32'h1234, 0, 5'd5, 1,
           0, 0, 0, -1, 0);

    // ALU op with taken branch
    wbq.push_back(mk_wb(32'h44, 5'd1, 1'b1, 1'b0, 1'b1));
    bq.push_back(32'h8000_0040);
    run_op("br", 0, 0, 3'd0, 32'h44, 0, 5'd1, 1,
           1, 32'h8000_0040, 0, -1, 0);

    // LB 0x103, ready in 3rd access cycle
    rqq.push_back(mk_rq(32'h100, 1'b0, 4'h0, 0));
    wbq.push_back(mk_wb(32'hFFFF_FF80, 5'd7, 1'b1, 1'b0, 1'b1));
    run_op("lb", 1, 0, 3'd0, 32'h103, 0, 5'd7, 1,
           0, 0, 32'h80AA_BBCC, 2, 3);

    // LBU same
    rqq.push_back(mk_rq(32'h100, 1'b0, 4'h0, 0));
    wbq.push_back(mk_wb(32'h0000_0080, 5'd8, 1'b1, 1'b0, 1'b1));
    run_op("lbu", 1, 0, 3'd4, 32'h103, 0, 5'd8, 1,
           0, 0, 32'h80AA_BBCC, 2, 3);

    // LH upper half, minimum latency
    rqq.push_back(mk_rq(32'h100, 1'b0, 4'h0, 0));
    wbq.push_back(mk_wb(32'hFFFF_80AA, 5'd9, 1'b1, 1'b0, 1'b1));
    run_op("lh", 1, 0, 3'd1, 32'h102, 0, 5'd9, 1,
           0, 0, 32'h80AA_BBCC, 0, 1);

    // LHU lower half
    rqq.push_back(mk_rq(32'h100, 1'b0, 4'h0, 0));
    wbq.push_back(mk_wb(32'h0000_BBCC, 5'd10, 1'b1, 1'b0, 1'b1));
    run_op("lhu", 1, 0, 3'd5, 32'h100, 0, 5'd10, 1,
           0, 0, 32'h80AA_BBCC, 1, 2);

    // LW
    rqq.push_back(mk_rq(32'h4, 1'b0, 4'h0, 0));
    wbq.push_back(mk_wb(32'h1234_5678, 5'd11, 1'b1, 1'b0, 1'b1));
    run_op("lw", 1, 0, 3'd2, 32'h4, 0, 5'd11, 1,
           0, 0, 32'h1234_5678, 0, 1);

    // SH 0x202
    rqq.push_back(mk_rq(32'h200, 1'b1, 4'b1100, 32'hBEEF_BEEF));
    wbq.push_back(mk_wb(0, 0, 1'b0, 1'b0, 1'b0));
    run_op("sh", 0, 1, 3'd1, 32'h202, 32'h0000_BEEF, 5'd3, 1,
           0, 0, 0, 1, 2);

    // SB 0x301
    rqq.push_back(mk_rq(32'h300, 1'b1, 4'b0010, 32'h5A5A_5A5A));
    wbq.push_back(mk_wb(0, 0, 1'b0, 1'b0, 1'b0));
    run_op("sb", 0, 1, 3'd0, 32'h301, 32'h1234_565A, 5'd3, 1,
           0, 0, 0, 0, 1);

    // SW 0x400
    rqq.push_back(mk_rq(32'h400, 1'b1, 4'b1111, 32'hDEAD_BEEF));
    wbq.push_back(mk_wb(0, 0, 1'b0, 1'b0, 1'b0));
    run_op("sw", 0, 1, 3'd2, 32'h400, 32'hDEAD_BEEF, 5'd3, 1,
           0, 0, 0, 0, 1);

    // error cases: no request, one-cycle error
    wbq.push_back(mk_wb(0, 0, 1'b0, 1'b1, 1'b0));
    run_op("lw_mis", 1, 0, 3'd2, 32'h6, 0, 5'd4, 1,
           0, 0, 0, -1, 0);
    wbq.push_back(mk_wb(0, 0, 1'b0, 1'b1, 1'b0));
    run_op("ld_f3", 1, 0, 3'd3, 32'h0, 0, 5'd4, 1,
           0, 0, 0, -1, 0);
    wbq.push_back(mk_wb(0, 0, 1'b0, 1'b1, 1'b0));
    run_op("rdwr", 1, 1, 3'd2, 32'h0, 0, 5'd4, 1,
           0, 0, 0, -1, 0);
    wbq.push_back(mk_wb(0, 0, 1'b0, 1'b1, 1'b0));
    run_op("st_f3", 0, 1, 3'd4, 32'h0, 0, 5'd4, 1,
           0, 0, 0, -1, 0);

    // timeout: no ready
    rqq.push_back(mk_rq(32'h10, 1'b0, 4'h0, 0));
    wbq.push_back(mk_wb(0, 0, 1'b0, 1'b1, 1'b0));
    run_op("tmo", 1, 0, 3'd2, 32'h10, 0, 5'd6, 1,
           0, 0, 0, -1, 4);

    // ready on the timeout edge wins
    rqq.push_back(mk_rq(32'h10, 1'b0, 4'h0, 0));
    wbq.push_back(mk_wb(32'hCAFE_F00D, 5'd6, 1'b1, 1'b0, 1'b1));
    run_op("tmo_rdy", 1, 0, 3'd2, 32'h10, 0, 5'd6, 1,
           0, 0, 32'hCAFE_F00D, 3, 4);

    // reset mid-access
    rqq.push_back(mk_rq(32'h20, 1'b0, 4'h0, 0));
    i_valid     = 1'b1;
    i_mem_read  = 1'b1;
    i_func3     = 3'd2;
    i_alu_out   = 32'h20;
    i_write_reg = 5'd12;
    i_reg_write = 1'b1;
    @(posedge clk); #1;
    chk("rstm_req", 32'(o_dmem_req), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstm_outs",
        {26'd0, o_wb_valid, o_dmem_req, o_stall,
         o_pc_src, o_mem_err, o_wb_reg_write}, 32'd0);
    chk("rstm_addr", o_dmem_addr, 32'd0);
    i_valid    = 1'b0;
    i_mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    i_dmem_ready = 1'b1;
    i_dmem_rdata = 32'hFFFF_FFFF;
    repeat (5) @(posedge clk);
    #1;
    i_dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    chk("wbq_empty", 32'(wbq.size()), 32'd0);
    chk("rqq_empty", 32'(rqq.size()), 32'd0);
    chk("bq_empty", 32'(bq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the ALU/execute stage; consumes the EX->MEM fields (ALU result, rd2, write_reg, MemToReg, RegWrite, branch, AddSum).
- Drives a single-outstanding data-memory request/ready handshake and performs load extraction (byte/half/word, signed/unsigned) and store byte-lane generation.
- Registers the result into the MEM->WB boundary, stalls upstream while a memory access is pending, and forwards the branch redirect to fetch.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in ACCESS without i_dmem_ready before the access is aborted (range 1..255)

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_reset  in  1  asynchronous, active-low reset
i_valid  in  1  EX->MEM entry valid this cycle
i_alu_out  in  32  ALUOutput: effective address or result
i_rd2  in  32  store data
i_write_reg  in  5  destination register
i_mem_to_reg  in  1  result comes from memory
i_reg_write  in  1  writes register file
i_mem_read  in  1  load
i_mem_write  in  1  store
i_func3  in  3  load/store size code (RV32I encoding)
i_branch  in  1  branch taken
i_add_sum  in  32  branch/jump target
o_stall  out  1  upstream must hold its EX->MEM entry
o_dmem_req  out  1  memory request
o_dmem_we  out  1  1=store, 0=load
o_dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
o_dmem_wdata  out  32  lane-positioned store data
o_dmem_be  out  4  byte enables
i_dmem_ready  in  1  request completes this cycle
i_dmem_rdata  in  32  load data, valid when i_dmem_ready=1
o_wb_valid  out  1  MEM->WB entry valid (1-cycle pulse per instruction)
o_wb_data  out  32  writeback value
o_wb_write_reg  out  5  destination register
o_wb_reg_write  out  1  register-file write enable
o_pc_src  out  1  redirect fetch (1-cycle pulse)
o_branch_target  out  32  redirect address
o_mem_err  out  1  1-cycle pulse: misaligned, illegal func3, read+write, or timeout

Behaviour:
- Reset (i_reset=0, asynchronous): state=IDLE, timeout counter=0, every output=0; any in-flight request is dropped immediately and never completes.
- FSM states: IDLE, ACCESS.
- o_stall=1 exactly when state=ACCESS (combinational from state).
- IDLE, i_valid=1, no memory op:
  - Next edge: o_wb_valid=1, o_wb_data=i_alu_out, o_wb_write_reg=i_write_reg, o_wb_reg_write=i_reg_write.
  - Latency 1 cycle.
- IDLE, i_valid=1, branch: o_pc_src=i_valid&i_branch and o_branch_target=i_add_sum, both registered, pulse for 1 cycle. This path is independent of the memory FSM.
- IDLE, i_valid=1, legal memory op:
  - Capture address, data, func3, and destination into holding registers.
  - Next edge: state=ACCESS and o_dmem_req=1. addr/we/wdata/be then remain stable until completion.
- ACCESS:
  - On the first edge where i_dmem_ready=1: o_dmem_req=0, state=IDLE, o_wb_valid=1.
  - Load completion: o_wb_data=extracted value and o_wb_reg_write=captured RegWrite.
  - Store completion: o_wb_reg_write=0.
  - Minimum load/store latency 2 cycles; i_dmem_ready while o_dmem_req=0 is ignored.
- Load extraction, offset off=addr[1:0]:
  - LB(0): sign-extended byte lane off.
  - LH(1): sign-extended half at off[1].
  - LW(2): full word.
  - LBU(4): zero-extended byte.
  - LHU(5): zero-extended half.
- Store lanes:
  - SB(0): be=1<<off, wdata={4{rd2[7:0]}}.
  - SH(1): be=off[1]?4'b1100:4'b0011, wdata={2{rd2[15:0]}}.
  - SW(2): be=4'b1111, wdata=rd2.
- Errors (no request issued): halfword access with off[0]=1; word access with off!=0; load func3 in {3,6,7}; store func3>2; i_mem_read&i_mem_write.
  - Next edge: o_mem_err=1, o_wb_valid=1, o_wb_reg_write=0, state stays IDLE.
- Timeout: counter clears on entry to ACCESS and increments each ACCESS cycle without ready. When it reaches TIMEOUT_CYCLES: drop o_dmem_req, o_mem_err=1, o_wb_valid=1, o_wb_reg_write=0, state=IDLE. Ready on the same edge as the timeout wins (normal completion).
- i_valid=0 in IDLE: o_wb_valid=0, o_pc_src=0; other WB outputs hold.

Test Plan:
- Reset mid-access: LW pending, i_reset low -> o_dmem_req, o_stall, and all outputs 0 immediately; no o_wb_valid after release.
- ALU op: i_alu_out=0x0000_1234, write_reg=5, reg_write=1 -> next cycle o_wb_valid=1, o_wb_data=0x1234, o_wb_write_reg=5, no o_dmem_req.
- LB at addr 0x103, ready 3 cycles late, rdata=0x80AA_BBCC:
  - o_dmem_addr=0x100, o_stall high 3 cycles.
  - o_wb_data=0xFFFF_FF80.
  - Same case as LBU -> 0x0000_0080.
- SH at 0x202, rd2=0x0000_BEEF -> o_dmem_be=4'b1100, o_dmem_wdata=0xBEEF_BEEF, o_dmem_we=1, o_wb_reg_write=0.
- LW at 0x006 -> no o_dmem_req, o_mem_err pulse, o_wb_reg_write=0; same for func3=3 load at 0x0 and read+write both set.
- TIMEOUT_CYCLES=4, ready never asserted -> o_mem_err on 4th ACCESS cycle, o_stall drops; repeat with ready on that edge -> normal completion, no error.
